serial_tx: RTL

Byte-serial UART-style transmitter. Accepts a parallel word over a valid/ready handshake and shifts it out on a single line as start bit, data bits LSB first, optional parity, then stop bit(s). It is the transmit end paired with the team's existing serial receiver, and drives stimulus into receiver loopback tests in the vlog regression suite.

---
 rtl/serial_tx.sv | 115 +++++++++++
 1 files changed

// File: rtl/serial_tx.sv
// UART-style transmitter: start bit, DATA_BITS LSB first, optional parity, STOP_BITS stop bits.
// Every output is registered; next-cycle values are derived from the next state.
module serial_tx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  initial begin
    if (DATA_BITS < 5 || DATA_BITS > 9) $fatal(1, "serial_tx: DATA_BITS out of range");
    if (CLKS_PER_BIT < 1)                $fatal(1, "serial_tx: CLKS_PER_BIT must be >= 1");
    if (PARITY < 0 || PARITY > 2)        $fatal(1, "serial_tx: PARITY must be 0..2");
    if (STOP_BITS != 1 && STOP_BITS != 2) $fatal(1, "serial_tx: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t                 state, state_d;
  logic [CW-1:0]          baud, baud_d;
  logic [3:0]             bitcnt, bitcnt_d;
  logic [DATA_BITS-1:0]   sh, sh_d;
  logic                   par, par_d;
  logic                   txd_d, done_d;
  logic                   wrap;

  assign wrap = (baud == BAUD_MAX);

  always_comb begin
    state_d  = state;
    baud_d   = baud;
    bitcnt_d = bitcnt;
    sh_d     = sh;
    par_d    = par;
    done_d   = 1'b0;
    if (state != IDLE) baud_d = wrap ? '0 : baud + CW'(1);
    unique case (state)
      IDLE: if (tx_valid && tx_ready) begin
        sh_d     = tx_data;
        par_d    = (^tx_data) ^ (PARITY == 2);
        baud_d   = '0;
        bitcnt_d = '0;
        state_d  = START;
      end
      START: if (wrap) state_d = DATA;
      DATA: if (wrap) begin
        sh_d = sh >> 1;
        if (bitcnt == DATA_LAST) begin
          bitcnt_d = '0;
          state_d  = (PARITY != 0) ? PAR : STOP;
        end else begin
          bitcnt_d = bitcnt + 4'd1;
        end
      end
      PAR: if (wrap) state_d = STOP;
      STOP: if (wrap) begin
        if (bitcnt == STOP_LAST) begin
          bitcnt_d = '0;
          state_d  = IDLE;
          done_d   = 1'b1;
        end else begin
          bitcnt_d = bitcnt + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line value for the coming cycle, so txd lands registered with no extra latency.
    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = sh_d[0];
      PAR:     txd_d = par_d;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud       <= '0;
      bitcnt     <= '0;
      sh         <= '0;
      par        <= 1'b0;
      txd        <= 1'b1;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      baud       <= baud_d;
      bitcnt     <= bitcnt_d;
      sh         <= sh_d;
      par        <= par_d;
      txd        <= txd_d;
      tx_ready   <= (state_d == IDLE);
      busy       <= (state_d != IDLE);
      frame_done <= done_d;
    end
  end

endmodule
